// File: rtl/pc_call_stack_if.sv
// Fetch-path bus between decode/jump logic (master) and the program counter (slave).
// Carries the control strobes, the jump/call target, and the PC/stack status.
interface pc_call_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in;
    logic             load;
    logic             call;
    logic             ret;
    logic             inc;
    logic [WIDTH-1:0] out;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output in, load, call, ret, inc,
        input  out, depth, full, empty, overflow, underflow
    );

    modport slave (
        input  in, load, call, ret, inc,
        output out, depth, full, empty, overflow, underflow
    );
endinterface

// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack.
// Applies one action per edge with priority reset > load > call > ret > inc > hold.
module pc_call_stack #(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input logic            clk,
    input logic            reset,
    pc_call_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

    logic [WIDTH-1:0] pc;
    logic [DW-1:0]    sp;
    logic             ovf;
    logic             unf;
    logic [WIDTH-1:0] stack [DEPTH];

    logic             is_full;
    logic             is_empty;
    logic             push;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] top;

    assign is_full  = (sp == DEPTH_V);
    assign is_empty = (sp == '0);
    assign pc_next  = pc + WIDTH'(1);
    // Asynchronous top-of-stack read so a return completes in a single edge.
    assign top      = stack[AW'(sp - DW'(1))];
    assign push     = !reset && !bus.load && bus.call && !is_full;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) stack[AW'(sp)] <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_ADDR;
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (bus.load) begin
            pc <= bus.in;
        end else if (bus.call) begin
            // The jump still happens on a full stack; only the push is lost.
            pc <= bus.in;
            if (is_full) ovf <= 1'b1;
            else         sp  <= sp + DW'(1);
        end else if (bus.ret) begin
            if (is_empty) begin
                unf <= 1'b1;
            end else begin
                pc <= top;
                sp <= sp - DW'(1);
            end
        end else if (bus.inc) begin
            pc <= pc_next;
        end
    end

    assign bus.out       = pc;
    assign bus.depth     = sp;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;
endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: queue-based reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_pc_call_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;

    pc_call_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pc_call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a PC value and a queue used as a bounded LIFO.
    logic [WIDTH-1:0] m_pc = '0;
    logic [WIDTH-1:0] m_stk[$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 16'h0000;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (bus.load) begin
            m_pc = bus.in;
        end else if (bus.call) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(16'(m_pc + 1));
            else m_ovf = 1'b1;
            m_pc = bus.in;
        end else if (bus.ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_unf = 1'b1;
        end else if (bus.inc) begin
            m_pc = 16'(m_pc + 1);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (bus.out !== m_pc || bus.depth !== DW'(m_stk.size()) ||
                bus.full !== (m_stk.size() == DEPTH) || bus.empty !== (m_stk.size() == 0) ||
                bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
                errors++;
                $display("FAIL model t=%0t out=%h/%h depth=%0d/%0d full=%b empty=%b ovf=%b/%b unf=%b/%b",
                         $time, bus.out, m_pc, bus.depth, m_stk.size(), bus.full, bus.empty,
                         bus.overflow, m_ovf, bus.underflow, m_unf);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Apply one set of strobes across one rising edge; returns at the following negedge.
    task automatic op(input bit r, input bit l, input bit c, input bit rt, input bit i,
                      input logic [WIDTH-1:0] a);
        reset    = r;
        bus.load = l;
        bus.call = c;
        bus.ret  = rt;
        bus.inc  = i;
        bus.in   = a;
        @(negedge clk);
    endtask

    initial begin
        bus.in = '0; bus.load = 0; bus.call = 0; bus.ret = 0; bus.inc = 0;
        @(negedge clk);

        // Reset and increment
        op(1, 0, 0, 0, 0, 16'h0);
        started = 1'b1;
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_depth", 32'(bus.depth), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            op(0, 0, 0, 0, 1, 16'h0);
            chk("inc_out", 32'(bus.out), 32'(k));
        end
        op(0, 0, 0, 0, 0, 16'hBEEF);
        chk("hold_out", 32'(bus.out), 32'h3);

        // Nested call/return
        op(0, 1, 0, 0, 0, 16'h0010);
        op(0, 0, 1, 0, 0, 16'h0100);
        chk("call1_out", 32'(bus.out), 32'h0100);
        chk("call1_depth", 32'(bus.depth), 32'd1);
        op(0, 0, 1, 0, 0, 16'h0200);
        chk("call2_out", 32'(bus.out), 32'h0200);
        chk("call2_depth", 32'(bus.depth), 32'd2);
        op(0, 0, 0, 1, 0, 16'h0);
        chk("ret1_out", 32'(bus.out), 32'h0101);
        chk("ret1_depth", 32'(bus.depth), 32'd1);
        op(0, 0, 0, 1, 0, 16'h0);
        chk("ret2_out", 32'(bus.out), 32'h0011);
        chk("ret2_depth", 32'(bus.depth), 32'd0);

        // Underflow, sticky across incs
        op(0, 1, 0, 0, 0, 16'h0042);
        op(0, 0, 0, 1, 0, 16'h0);
        chk("unf_out", 32'(bus.out), 32'h0042);
        chk("unf_flag", 32'(bus.underflow), 32'd1);
        op(0, 0, 0, 0, 1, 16'h0);
        op(0, 0, 0, 0, 1, 16'h0);
        chk("unf_sticky", 32'(bus.underflow), 32'd1);
        chk("unf_inc_out", 32'(bus.out), 32'h0044);

        // Overflow: pushes are 0x0001, then 0x1001 + 0x10*k
        op(1, 0, 0, 0, 0, 16'h0);
        chk("rst2_unf", 32'(bus.underflow), 32'd0);
        for (int k = 0; k < 8; k++) op(0, 0, 1, 0, 0, 16'(16'h1000 + k * 16));
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_ovf", 32'(bus.overflow), 32'd0);
        op(0, 0, 1, 0, 0, 16'h0AAA);
        chk("ovf_out", 32'(bus.out), 32'h0AAA);
        chk("ovf_depth", 32'(bus.depth), 32'd8);
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int k = 7; k >= 1; k--) begin
            op(0, 0, 0, 1, 0, 16'h0);
            chk("lifo_pop", 32'(bus.out), 32'(16'h1000 + (k - 1) * 16 + 1));
        end
        op(0, 0, 0, 1, 0, 16'h0);
        chk("lifo_last", 32'(bus.out), 32'h0001);
        chk("lifo_empty", 32'(bus.empty), 32'd1);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Priority
        op(1, 0, 0, 0, 0, 16'h0);
        op(0, 1, 0, 0, 0, 16'h0005);
        op(0, 1, 1, 1, 1, 16'h0300);
        chk("prio_load_out", 32'(bus.out), 32'h0300);
        chk("prio_load_depth", 32'(bus.depth), 32'd0);
        op(0, 0, 1, 1, 1, 16'h0400);
        chk("prio_call_out", 32'(bus.out), 32'h0400);
        chk("prio_call_depth", 32'(bus.depth), 32'd1);
        op(0, 0, 0, 1, 1, 16'h0);
        chk("prio_ret_out", 32'(bus.out), 32'h0301);

        // Wrap and reset mid-operation
        op(0, 1, 0, 0, 0, 16'hFFFF);
        op(0, 0, 1, 0, 0, 16'h1234);
        chk("wrap_call", 32'(bus.out), 32'h1234);
        op(0, 0, 0, 1, 0, 16'h0);
        chk("wrap_ret", 32'(bus.out), 32'h0000);
        op(0, 1, 0, 0, 0, 16'hFFFF);
        op(0, 0, 0, 0, 1, 16'h0);
        chk("wrap_inc", 32'(bus.out), 32'h0000);
        op(0, 0, 1, 0, 0, 16'h2222);
        op(0, 0, 0, 1, 0, 16'h0);
        op(0, 0, 0, 1, 0, 16'h0);
        chk("pre_rst_unf", 32'(bus.underflow), 32'd1);
        op(0, 0, 1, 0, 0, 16'h3333);
        op(1, 0, 1, 0, 0, 16'h5555);
        chk("rstcall_out", 32'(bus.out), 32'h0000);
        chk("rstcall_depth", 32'(bus.depth), 32'd0);
        chk("rstcall_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        op(0, 0, 0, 0, 0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised program counter with a built-in hardware return-address stack. It extends the basic reset/load/increment counter with call and return operations, configurable address width and stack depth, and stack fullness and error status. It sits in the CPU fetch path, drives the instruction-memory address, and takes its control strobes from the decode/jump logic.

## Interface
- WIDTH, 16: address width in bits; must be at least 2.
- DEPTH, 8: number of return-address stack entries; must be at least 2; need not be a power of two.
- RESET_ADDR, 0: value loaded into `out` on reset.
- DW, derived as $clog2(DEPTH+1): width of the `depth` output.

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- in  input  WIDTH  jump or call target.
- load  input  1  jump: `out` <= `in`.
- call  input  1  push `out`+1, then `out` <= `in`.
- ret  input  1  pop the stack top into `out`.
- inc  input  1  `out` <= `out`+1.
- out  output  WIDTH  current program counter; registered.
- depth  output  DW  number of valid stack entries; registered.
- full  output  1  high when `depth` == DEPTH; combinational from the `depth` register.
- empty  output  1  high when `depth` == 0; combinational from the `depth` register.
- overflow  output  1  sticky; set by a call while full.
- underflow  output  1  sticky; set by a return while empty.

## Operation
Each rising edge performs exactly one action, chosen by this strict priority: reset > load > call > ret > inc > hold.

- **reset**
  - `out` = RESET_ADDR, `depth` = 0, `overflow` = 0, `underflow` = 0.
  - Stack RAM contents are don't-care.
  - Reset wins in any cycle, including mid-sequence.
- **load**
  - `out` <= `in`.
  - Stack, `depth` and flags are unchanged, even if `call`, `ret` or `inc` are also high.
- **call, not full**
  - stack[`depth`] <= (`out`+1) mod 2^WIDTH; `depth` <= `depth`+1; `out` <= `in`.
- **call while full**
  - `out` <= `in`; the push is dropped; `depth` is unchanged; `overflow` <= 1.
  - Existing entries are not overwritten.
- **ret, not empty**
  - `out` <= stack[`depth`-1]; `depth` <= `depth`-1.
- **ret while empty**
  - `out` holds; `depth` stays 0; `underflow` <= 1.
- **inc**
  - `out` <= (`out`+1) mod 2^WIDTH.
  - Wraps from all-ones to 0 with no flag.
- **hold**
  - No strobe active: all state is unchanged.

Arithmetic and stack rules:
- All address arithmetic is unsigned and truncated to WIDTH bits.
- A call from address all-ones pushes 0.
- The stack is strictly LIFO.
- `overflow` and `underflow` clear only on reset.

## Timing
- `out` and `depth` update on the same edge as the qualifying strobe (latency 1 edge).
- No combinational path from any input to any output.
- `full` and `empty` follow `depth` with no extra cycle of delay.
- Back-to-back operations are legal every cycle, with no bubbles:
  - call on edge N followed by ret on edge N+1 returns `out` to the call-site address + 1.
  - ret in the cycle immediately after a push reads the newly pushed entry.
- Stack storage may be registers or distributed RAM. Read of the top entry is asynchronous within the cycle so that ret completes in one edge.

## Test plan
- **Reset and increment:** with RESET_ADDR=0, assert reset, then inc for 3 cycles -> `out` = 0, 1, 2, 3; `depth` = 0; `empty` = 1.
- **Nested call/return:** starting from `out`=0x0010, call `in`=0x0100, then call `in`=0x0200, then ret, then ret -> `out` = 0x0100, 0x0200, 0x0101, 0x0011; `depth` = 1, 2, 1, 0.
- **Overflow:** with DEPTH=8, perform 9 calls, the 9th to 0x0AAA -> `out` = 0x0AAA, `depth` = 8, `full` = 1, `overflow` = 1. Then 8 rets -> returns follow the first 8 pushes in LIFO order.
- **Underflow:** ret with `depth`=0 and `out`=0x0042 -> `out` stays 0x0042; `underflow` = 1 and remains 1 after further incs until reset.
- **Priority:** with `out`=0x0005, assert load+call+ret+inc together with `in`=0x0300 -> `out` = 0x0300 and `depth` unchanged. Next cycle, assert call+ret+inc with `in`=0x0400 -> `out` = 0x0400 and `depth` +1 with 0x0301 pushed.
- **Wrap and reset mid-operation:** call from `out`=0xFFFF to 0x1234, then ret -> `out` = 0x0000. Then a reset asserted together with call -> `out` = RESET_ADDR, `depth` = 0, both flags = 0.
